// File: rtl/buf_wr_arbiter_rr.sv
// -----------------------------------------------------------------------------
// buf_wr_arbiter_rr
//   Packet-level round-robin arbiter sharing the single buffer write path and
//   the address manager free-list head among NUM_PORTS AXI-Stream ingress
//   ports. A port owns the write path for one whole packet. Each stored word
//   is written at the current free-list head and advances it by one. A
//   descriptor (start address, word count, source port, truncation flag) is
//   offered once per packet.
//
//   FSM: IDLE (arbitrate) -> BURST (move words) -> DESC (offer descriptor).
// -----------------------------------------------------------------------------
module buf_wr_arbiter_rr #(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_WIDTH    = 256,
    parameter int ADDR_WIDTH    = 12,
    parameter int LEN_WIDTH     = 6,
    parameter int MAX_PKT_WORDS = 48
) (
    input  logic                            clk,
    input  logic                            rstn,
    // Ingress AXI-Stream ports
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    // Address manager
    input  logic [ADDR_WIDTH-1:0]           am_fl_head,
    input  logic                            am_almost_full,
    output logic                            am_wr_en,
    // Buffer RAM write port
    output logic                            buf_wr_en,
    output logic [ADDR_WIDTH-1:0]           buf_wr_addr,
    output logic [DATA_WIDTH-1:0]           buf_wr_data,
    // Descriptor to scheduler
    output logic                            desc_valid,
    input  logic                            desc_ready,
    output logic [ADDR_WIDTH-1:0]           desc_addr,
    output logic [LEN_WIDTH-1:0]            desc_len,
    output logic [$clog2(NUM_PORTS)-1:0]    desc_port,
    output logic                            desc_err
);

    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int CNT_W  = $clog2(MAX_PKT_WORDS + 1);

    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_PKT_WORDS);
    localparam logic [PORT_W:0]   NUM_P_EXT = (PORT_W + 1)'(NUM_PORTS);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DESC  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                r_state;
    logic [PORT_W-1:0]     r_rr_ptr;      // first port considered next arbitration
    logic [PORT_W-1:0]     r_grant;       // port owning the current packet
    logic [CNT_W-1:0]      r_count;       // words stored so far in this packet
    logic                  r_err;         // a word of this packet was discarded
    logic [ADDR_WIDTH-1:0] r_desc_addr;
    logic [LEN_WIDTH-1:0]  r_desc_len;
    logic [PORT_W-1:0]     r_desc_port;
    logic                  r_desc_err;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t                w_state_nxt;
    logic                  w_req_found;   // some port requests in IDLE
    logic [PORT_W-1:0]     w_req_idx;     // winning port of the round-robin scan
    logic                  w_grant_now;   // IDLE grant taken this cycle
    logic                  w_beat;        // granted port transfers a word
    logic                  w_last;        // that word ends the packet
    logic                  w_store;       // word fits in MAX_PKT_WORDS and is written
    logic                  w_first;       // word is the first of the packet
    logic [CNT_W-1:0]      w_count_inc;   // stored words including this beat
    logic [PORT_W-1:0]     w_rr_nxt;      // port after the granted one, wrapped

    // Round-robin scan: first requesting port at or after the pointer, wrapping.
    always_comb begin
        logic [PORT_W:0]   v_sum;
        logic [PORT_W-1:0] v_sel;
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_req_found = 1'b0;
        w_req_idx   = '0;
        v_sum       = '0;
        v_sel       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (PORT_W + 1)'(k);
            if (v_sum >= NUM_P_EXT) begin
                v_sum = v_sum - NUM_P_EXT;
            end
            v_sel = v_sum[PORT_W-1:0];
            if (!w_req_found && s_axis_tvalid[v_sel]) begin
                w_req_found = 1'b1;
                w_req_idx   = v_sel;
            end
        end
    end

    // Beat qualification for the port that currently owns the write path.
    always_comb begin
        w_grant_now = (r_state == ST_IDLE) && w_req_found && !am_almost_full;
        w_beat      = (r_state == ST_BURST) && s_axis_tvalid[r_grant];
        w_last      = s_axis_tlast[r_grant];
        w_store     = w_beat && (r_count < MAX_CNT);
        w_first     = w_beat && (r_count == '0);
        w_count_inc = r_count + CNT_W'(1);
        w_rr_nxt    = (r_grant == LAST_PORT) ? '0 : r_grant + PORT_W'(1);
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // Advance the FSM; synchronous active-low reset returns it to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision: grant, end of packet, descriptor handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_now) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_beat && w_last) begin
                    w_state_nxt = ST_DESC;
                end
            end
            ST_DESC: begin
                if (desc_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: ready to the owner only, write strobes only on stored beats.
    always_comb begin
        s_axis_tready = '0;
        if (r_state == ST_BURST) begin
            s_axis_tready[r_grant] = 1'b1;
        end
        buf_wr_en   = w_store;
        am_wr_en    = w_store;
        buf_wr_addr = am_fl_head;
        buf_wr_data = s_axis_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
        desc_valid  = (r_state == ST_DESC);
        desc_addr   = r_desc_addr;
        desc_len    = r_desc_len;
        desc_port   = r_desc_port;
        desc_err    = r_desc_err;
    end

    // -------------------------------------------------------------------------
    // Packet datapath: grant, word count, round-robin pointer, descriptor fields
    // -------------------------------------------------------------------------
    // Track the granted packet and capture its descriptor on first and last beat.
    always_ff @(posedge clk) begin
        // NOTE: descriptor fields are reset too, so the scheduler never sees X
        // on them even though desc_valid already qualifies them.
        if (!rstn) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_desc_addr <= '0;
            r_desc_len  <= '0;
            r_desc_port <= '0;
            r_desc_err  <= 1'b0;
        end else begin
            if (w_grant_now) begin
                r_grant <= w_req_idx;
                r_count <= '0;
                r_err   <= 1'b0;
            end

            if (w_beat) begin
                if (w_store) begin
                    r_count <= w_count_inc;
                end else begin
                    r_err <= 1'b1;
                end

                if (w_first) begin
                    r_desc_addr <= am_fl_head;
                    r_desc_port <= r_grant;
                end

                if (w_last) begin
                    // A discarded last beat leaves the count saturated at MAX.
                    r_desc_len <= w_store ? LEN_WIDTH'(w_count_inc)
                                          : LEN_WIDTH'(r_count);
                    r_desc_err <= r_err | ~w_store;
                    r_rr_ptr   <= w_rr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_buf_wr_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_buf_wr_arbiter_rr
//   Directed bench for buf_wr_arbiter_rr. Inputs change 1 ns after the rising
//   edge; outputs are sampled on the falling edge. The bench plays the address
//   manager by supplying am_fl_head values explicitly.
// -----------------------------------------------------------------------------
module tb_buf_wr_arbiter_rr;

    localparam int NP = 4;
    localparam int DW = 256;
    localparam int AW = 12;
    localparam int LW = 6;
    localparam int MW = 48;

    logic           clk;
    logic           rstn;
    logic [NP*DW-1:0] s_axis_tdata;
    logic [NP-1:0]  s_axis_tvalid;
    logic [NP-1:0]  s_axis_tlast;
    logic [NP-1:0]  s_axis_tready;
    logic [AW-1:0]  am_fl_head;
    logic           am_almost_full;
    logic           am_wr_en;
    logic           buf_wr_en;
    logic [AW-1:0]  buf_wr_addr;
    logic [DW-1:0]  buf_wr_data;
    logic           desc_valid;
    logic           desc_ready;
    logic [AW-1:0]  desc_addr;
    logic [LW-1:0]  desc_len;
    logic [1:0]     desc_port;
    logic           desc_err;

    int checks   = 0;
    int failures = 0;

    buf_wr_arbiter_rr #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .LEN_WIDTH(LW), .MAX_PKT_WORDS(MW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .am_fl_head    (am_fl_head),
        .am_almost_full(am_almost_full),
        .am_wr_en      (am_wr_en),
        .buf_wr_en     (buf_wr_en),
        .buf_wr_addr   (buf_wr_addr),
        .buf_wr_data   (buf_wr_data),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_addr     (desc_addr),
        .desc_len      (desc_len),
        .desc_port     (desc_port),
        .desc_err      (desc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each port's data word encodes its index and the current head address.
    function automatic logic [DW-1:0] make_data(input logic [7:0] p, input logic [AW-1:0] h);
        return {8'hA5, 224'd0, p, 4'h0, h};
    endfunction

    always_comb begin
        s_axis_tdata = '0;
        for (int p = 0; p < NP; p++) begin
            s_axis_tdata[p*DW +: DW] = make_data(8'(p), am_fl_head);
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        desc_ready    = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  last;
        logic [11:0] head;
        logic        afull;
        logic        dready;
        logic [3:0]  e_tready;
        logic        e_wr;
        logic [7:0]  e_wport;
        logic        e_dvalid;
        logic [11:0] e_daddr;
        logic [5:0]  e_dlen;
        logic [1:0]  e_dport;
        logic        e_derr;
    } vec_t;

    vec_t vecs[6];

    logic [3:0]  exp_rdy;
    logic [11:0] head_m;
    int          beats;
    int          writes;

    initial begin
        am_fl_head     = '0;
        am_almost_full = 1'b0;
        desc_ready     = 1'b0;
        s_axis_tvalid  = '0;
        s_axis_tlast   = '0;
        rstn           = 1'b0;

        // ---- 1: reset with every port requesting ----
        s_axis_tvalid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            mid();
            check("rst_tready", DW'(s_axis_tready), DW'(4'b0000));
            check("rst_desc_valid", DW'(desc_valid), DW'(1'b0));
            check("rst_am_wr_en", DW'(am_wr_en), DW'(1'b0));
            check("rst_buf_wr_en", DW'(buf_wr_en), DW'(1'b0));
        end
        check("rst_desc_fields", DW'({desc_addr, desc_len, desc_port, desc_err}), DW'(0));
        do_reset();

        // ---- 2: single 3-word packet on port 2, table driven ----
        vecs[0] = '{4'b0100, 4'b0000, 12'd5, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0, 12'd0, 6'd0, 2'd0, 1'b0};
        vecs[1] = '{4'b0100, 4'b0000, 12'd5, 1'b0, 1'b1, 4'b0100, 1'b1, 8'd2, 1'b0, 12'd0, 6'd0, 2'd0, 1'b0};
        vecs[2] = '{4'b0100, 4'b0000, 12'd6, 1'b0, 1'b1, 4'b0100, 1'b1, 8'd2, 1'b0, 12'd0, 6'd0, 2'd0, 1'b0};
        vecs[3] = '{4'b0100, 4'b0100, 12'd7, 1'b0, 1'b1, 4'b0100, 1'b1, 8'd2, 1'b0, 12'd0, 6'd0, 2'd0, 1'b0};
        vecs[4] = '{4'b0000, 4'b0000, 12'd8, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b1, 12'd5, 6'd3, 2'd2, 1'b0};
        vecs[5] = '{4'b0000, 4'b0000, 12'd8, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0, 12'd0, 6'd0, 2'd0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            s_axis_tvalid  = vecs[i].vld;
            s_axis_tlast   = vecs[i].last;
            am_fl_head     = vecs[i].head;
            am_almost_full = vecs[i].afull;
            desc_ready     = vecs[i].dready;
            mid();
            check($sformatf("v%0d_tready", i), DW'(s_axis_tready), DW'(vecs[i].e_tready));
            check($sformatf("v%0d_buf_wr_en", i), DW'(buf_wr_en), DW'(vecs[i].e_wr));
            check($sformatf("v%0d_am_wr_en", i), DW'(am_wr_en), DW'(vecs[i].e_wr));
            if (vecs[i].e_wr) begin
                check($sformatf("v%0d_wr_addr", i), DW'(buf_wr_addr), DW'(vecs[i].head));
                check($sformatf("v%0d_wr_data", i), buf_wr_data, make_data(vecs[i].e_wport, vecs[i].head));
            end
            check($sformatf("v%0d_desc_valid", i), DW'(desc_valid), DW'(vecs[i].e_dvalid));
            if (vecs[i].e_dvalid) begin
                check($sformatf("v%0d_desc", i), DW'({desc_addr, desc_len, desc_port, desc_err}),
                      DW'({vecs[i].e_daddr, vecs[i].e_dlen, vecs[i].e_dport, vecs[i].e_derr}));
            end
            tick();
        end

        // ---- 3: all ports requesting 1-word packets, order 0,1,2,3,0 ----
        do_reset();
        s_axis_tvalid = 4'b1111;
        s_axis_tlast  = 4'b1111;
        desc_ready    = 1'b1;
        head_m        = 12'd20;
        am_fl_head    = head_m;
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            mid();
            check($sformatf("rr%0d_idle_tready", k), DW'(s_axis_tready), DW'(4'b0000));
            tick();
            mid();
            check($sformatf("rr%0d_tready", k), DW'(s_axis_tready), DW'(exp_rdy));
            check($sformatf("rr%0d_wr", k), DW'({buf_wr_en, buf_wr_addr}), DW'({1'b1, head_m}));
            tick();
            head_m     = head_m + 12'd1;
            am_fl_head = head_m;
            mid();
            check($sformatf("rr%0d_desc", k), DW'({desc_valid, desc_addr, desc_port, desc_len}),
                  DW'({1'b1, 12'(20 + k), 2'(k % 4), 6'd1}));
            check($sformatf("rr%0d_desc_tready", k), DW'(s_axis_tready), DW'(4'b0000));
            tick();
        end

        // ---- 4: almost-full holds arbitration in IDLE ----
        do_reset();
        s_axis_tvalid  = 4'b0010;
        s_axis_tlast   = 4'b0010;
        am_almost_full = 1'b1;
        am_fl_head     = 12'd60;
        desc_ready     = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mid();
            check($sformatf("afull_hold%0d", c), DW'(s_axis_tready), DW'(4'b0000));
            tick();
        end
        am_almost_full = 1'b0;
        mid();
        check("afull_release_same_cycle", DW'(s_axis_tready), DW'(4'b0000));
        tick();
        mid();
        check("afull_release_grant", DW'(s_axis_tready), DW'(4'b0010));
        tick();
        mid();
        check("afull_desc", DW'({desc_valid, desc_addr, desc_port, desc_len}), DW'({1'b1, 12'd60, 2'd1, 6'd1}));
        tick();

        // ---- 5: 50-word packet on port 0 is truncated to 48 ----
        do_reset();
        s_axis_tvalid = 4'b0001;
        s_axis_tlast  = 4'b0000;
        desc_ready    = 1'b1;
        head_m        = 12'd100;
        am_fl_head    = head_m;
        beats         = 0;
        writes        = 0;
        mid();
        tick();
        for (int i = 0; i < 50; i++) begin
            s_axis_tlast = (i == 49) ? 4'b0001 : 4'b0000;
            mid();
            if (s_axis_tready[0]) beats++;
            if (buf_wr_en) writes++;
            check($sformatf("long_wr%0d", i), DW'(buf_wr_en), DW'(i < MW));
            tick();
            if (i < MW) begin
                head_m     = head_m + 12'd1;
                am_fl_head = head_m;
            end
        end
        check("long_beats", DW'(beats), DW'(50));
        check("long_writes", DW'(writes), DW'(48));
        mid();
        check("long_desc", DW'({desc_valid, desc_addr, desc_len, desc_port, desc_err}),
              DW'({1'b1, 12'd100, 6'd48, 2'd0, 1'b1}));
        tick();

        // ---- 6: descriptor back-pressure, then reset mid-burst ----
        do_reset();
        s_axis_tvalid = 4'b1000;
        s_axis_tlast  = 4'b0000;
        desc_ready    = 1'b0;
        am_fl_head    = 12'd40;
        mid();
        tick();
        mid();
        tick();
        am_fl_head   = 12'd41;
        s_axis_tlast = 4'b1000;
        mid();
        check("bp_last_beat", DW'({s_axis_tready, buf_wr_en, buf_wr_addr}), DW'({4'b1000, 1'b1, 12'd41}));
        tick();
        s_axis_tvalid = 4'b0001;
        s_axis_tlast  = 4'b0000;
        am_fl_head    = 12'd42;
        for (int c = 0; c < 5; c++) begin
            mid();
            check($sformatf("bp_hold%0d", c), DW'({desc_valid, desc_addr, desc_len, desc_port, desc_err, s_axis_tready}),
                  DW'({1'b1, 12'd40, 6'd2, 2'd3, 1'b0, 4'b0000}));
            tick();
        end
        desc_ready = 1'b1;
        mid();
        check("bp_accept", DW'(desc_valid), DW'(1'b1));
        tick();
        mid();
        check("bp_idle", DW'({desc_valid, s_axis_tready}), DW'({1'b0, 4'b0000}));
        tick();
        mid();
        check("bp_next_grant", DW'({s_axis_tready, buf_wr_en}), DW'({4'b0001, 1'b1}));
        tick();
        rstn = 1'b0;
        mid();
        check("midrst_pre", DW'(s_axis_tready), DW'(4'b0001));
        tick();
        mid();
        check("midrst_out", DW'({s_axis_tready, desc_valid, buf_wr_en, am_wr_en}), DW'(0));
        tick();
        rstn          = 1'b1;
        s_axis_tvalid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            mid();
            check($sformatf("midrst_nodesc%0d", c), DW'({desc_valid, s_axis_tready}), DW'(0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
